mem_wb_stage: RTL and testbench

MEM_WB_STAGE -- requirements
Module: mem_wb_stage

---
 rtl/mips_pkg.sv | 16 +
 rtl/load_extender.sv | 37 +++
 rtl/mem_wb_stage.sv | 127 ++++++++++++
 tb/tb_mem_wb_stage.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: default datapath widths and the
// load-size mask encoding used by the MEM/WB stage.
package mips_pkg;

    localparam int MIPS_DATA_WIDTH     = 32;
    localparam int MIPS_REG_ADDR_WIDTH = 5;

    // {mask_1, mask_2} as presented by the decoder
    typedef enum logic [1:0] {
        MASK_WORD = 2'b00,
        MASK_3B   = 2'b01,
        MASK_HALF = 2'b10,
        MASK_BYTE = 2'b11
    } mask_e;

endpackage

// File: rtl/load_extender.sv
// Combinational load-data extender: selects the loaded field by mask and
// fills the upper bits with the field's sign bit, or zeros for unsigned loads.
module load_extender
    import mips_pkg::*;
#(
    parameter int DATA_WIDTH = MIPS_DATA_WIDTH
) (
    input  logic [DATA_WIDTH-1:0] data,
    input  mask_e                 mask,
    input  logic                  uns,
    output logic [DATA_WIDTH-1:0] ext
);

    logic sign;

    // Field select and sign/zero fill
    always_comb begin
        ext  = data;
        sign = 1'b0;
        case (mask)
            MASK_3B: begin
                sign = data[23] & ~uns;
                ext  = {{(DATA_WIDTH-24){sign}}, data[23:0]};
            end
            MASK_HALF: begin
                sign = data[15] & ~uns;
                ext  = {{(DATA_WIDTH-16){sign}}, data[15:0]};
            end
            MASK_BYTE: begin
                sign = data[7] & ~uns;
                ext  = {{(DATA_WIDTH-8){sign}}, data[7:0]};
            end
            default: ext = data;
        endcase
    end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline stage. S1 captures control and the ALU result alongside
// the data-memory address; the registered memory returns load data one edge
// later, which is extended and merged into S2 (the writeback outputs).
// A hold register keeps the load data stable across stalls.
// Optional: define MEM_WB_RETIRE_CNT_EN to add a 32-bit retire counter.
module mem_wb_stage
    import mips_pkg::*;
#(
    parameter int DATA_WIDTH     = MIPS_DATA_WIDTH,
    parameter int REG_ADDR_WIDTH = MIPS_REG_ADDR_WIDTH
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      i_valid,
    input  logic                      i_reg_write,
    input  logic                      i_mem_to_reg,
    input  logic                      i_unsigned,
    input  logic                      i_mask_1,
    input  logic                      i_mask_2,
    input  logic [REG_ADDR_WIDTH-1:0] i_rd,
    input  logic [DATA_WIDTH-1:0]     i_alu_result,
    input  logic [DATA_WIDTH-1:0]     i_read_data,
    input  logic                      i_stall,
    input  logic                      i_flush,
    output logic                      o_wb_valid,
    output logic                      o_wb_reg_write,
    output logic [REG_ADDR_WIDTH-1:0] o_wb_rd,
    output logic [DATA_WIDTH-1:0]     o_wb_data
`ifdef MEM_WB_RETIRE_CNT_EN
    ,
    output logic [31:0]               o_retire_count
`endif
);

    logic                      s1_valid;
    logic                      s1_reg_write;
    logic                      s1_mem_to_reg;
    logic                      s1_unsigned;
    mask_e                     s1_mask;
    logic [REG_ADDR_WIDTH-1:0] s1_rd;
    logic [DATA_WIDTH-1:0]     s1_alu_result;

    logic                      hold_valid;
    logic [DATA_WIDTH-1:0]     hold_data;
    logic [DATA_WIDTH-1:0]     load_data;
    logic [DATA_WIDTH-1:0]     ext_data;
    logic [DATA_WIDTH-1:0]     wb_data;

    // S1: capture MEM-stage control with the address; flush kills the slot
    // even while stalled
    always_ff @(posedge clk) begin
        if (!rst) begin
            s1_valid      <= 1'b0;
            s1_reg_write  <= 1'b0;
            s1_mem_to_reg <= 1'b0;
            s1_unsigned   <= 1'b0;
            s1_mask       <= MASK_WORD;
            s1_rd         <= '0;
            s1_alu_result <= '0;
        end else begin
            if (!i_stall) begin
                s1_valid      <= i_valid;
                s1_reg_write  <= i_reg_write;
                s1_mem_to_reg <= i_mem_to_reg;
                s1_unsigned   <= i_unsigned;
                s1_mask       <= mask_e'({i_mask_1, i_mask_2});
                s1_rd         <= i_rd;
                s1_alu_result <= i_alu_result;
            end
            if (i_flush)
                s1_valid <= 1'b0;
        end
    end

    // Hold register: the memory output is only valid for one cycle, so grab
    // it on the first stalled edge of a pending load and reuse it on release
    always_ff @(posedge clk) begin
        if (!rst) begin
            hold_valid <= 1'b0;
            hold_data  <= '0;
        end else if (i_flush || !i_stall) begin
            hold_valid <= 1'b0;
        end else if (s1_valid && s1_mem_to_reg && !hold_valid) begin
            hold_valid <= 1'b1;
            hold_data  <= i_read_data;
        end
    end

    assign load_data = hold_valid ? hold_data : i_read_data;

    load_extender #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_ext (
        .data (load_data),
        .mask (s1_mask),
        .uns  (s1_unsigned),
        .ext  (ext_data)
    );

    assign wb_data = s1_mem_to_reg ? ext_data : s1_alu_result;

    // S2: writeback outputs; writes to r0 are suppressed here
    always_ff @(posedge clk) begin
        if (!rst) begin
            o_wb_valid     <= 1'b0;
            o_wb_reg_write <= 1'b0;
            o_wb_rd        <= '0;
            o_wb_data      <= '0;
        end else if (!i_stall) begin
            o_wb_valid     <= s1_valid;
            o_wb_reg_write <= s1_valid & s1_reg_write & (s1_rd != '0);
            o_wb_rd        <= s1_rd;
            o_wb_data      <= wb_data;
        end
    end

`ifdef MEM_WB_RETIRE_CNT_EN
    // Retire counter: one count per valid instruction entering S2
    always_ff @(posedge clk) begin
        if (!rst)
            o_retire_count <= '0;
        else if (!i_stall && s1_valid)
            o_retire_count <= o_retire_count + 32'd1;
    end
`endif

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed bench for mem_wb_stage. Each drive() presents one MEM-stage slot
// plus the read data belonging to the slot issued one edge earlier, then
// samples 1 time unit after the rising edge.
module tb_mem_wb_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_valid, i_reg_write, i_mem_to_reg, i_unsigned, i_mask_1, i_mask_2;
    logic [4:0]  i_rd;
    logic [31:0] i_alu_result, i_read_data;
    logic        i_stall, i_flush;
    logic        o_wb_valid, o_wb_reg_write;
    logic [4:0]  o_wb_rd;
    logic [31:0] o_wb_data;
`ifdef MEM_WB_RETIRE_CNT_EN
    logic [31:0] o_retire_count;
`endif

    int nchk  = 0;
    int nfail = 0;

    mem_wb_stage #(.DATA_WIDTH(32), .REG_ADDR_WIDTH(5)) dut (
        .clk            (clk),
        .rst            (rst),
        .i_valid        (i_valid),
        .i_reg_write    (i_reg_write),
        .i_mem_to_reg   (i_mem_to_reg),
        .i_unsigned     (i_unsigned),
        .i_mask_1       (i_mask_1),
        .i_mask_2       (i_mask_2),
        .i_rd           (i_rd),
        .i_alu_result   (i_alu_result),
        .i_read_data    (i_read_data),
        .i_stall        (i_stall),
        .i_flush        (i_flush),
        .o_wb_valid     (o_wb_valid),
        .o_wb_reg_write (o_wb_reg_write),
        .o_wb_rd        (o_wb_rd),
        .o_wb_data      (o_wb_data)
`ifdef MEM_WB_RETIRE_CNT_EN
        ,
        .o_retire_count (o_retire_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got 0x%08h want 0x%08h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic rw, input logic m2r, input logic uns,
                         input logic [1:0] mask, input logic [4:0] rd,
                         input logic [31:0] alu, input logic [31:0] rdata);
        i_valid      = v;
        i_reg_write  = rw;
        i_mem_to_reg = m2r;
        i_unsigned   = uns;
        {i_mask_1, i_mask_2} = mask;
        i_rd         = rd;
        i_alu_result = alu;
        i_read_data  = rdata;
        step();
    endtask

    task automatic chk_wb(input string tag, input logic v, input logic rw,
                          input logic [4:0] rd, input logic [31:0] data);
        chk({tag, ".valid"}, {31'd0, o_wb_valid}, {31'd0, v});
        chk({tag, ".rw"},    {31'd0, o_wb_reg_write}, {31'd0, rw});
        chk({tag, ".rd"},    {27'd0, o_wb_rd}, {27'd0, rd});
        chk({tag, ".data"},  o_wb_data, data);
    endtask

    initial begin
        rst = 1'b0; i_stall = 1'b0; i_flush = 1'b0;
        drive(1, 1, 1, 0, 2'b11, 5'd7, 32'h100, 32'hFFFF_FFFF);
        drive(1, 1, 1, 0, 2'b11, 5'd7, 32'h100, 32'hFFFF_FFFF);
        chk_wb("reset", 0, 0, 5'd0, 32'h0);
`ifdef MEM_WB_RETIRE_CNT_EN
        chk("reset.cnt", o_retire_count, 32'd0);
`endif
        rst = 1'b1;

        // back-to-back loads of every size, then ALU ops
        drive(1, 1, 1, 0, 2'b11, 5'd3, 32'h100, 32'h0);            // A: lb
        drive(1, 1, 1, 1, 2'b11, 5'd4, 32'h104, 32'h0000_0080);    // B: lbu, rdata A
        chk_wb("lb", 1, 1, 5'd3, 32'hFFFF_FF80);
        drive(1, 1, 1, 0, 2'b10, 5'd5, 32'h108, 32'h0000_0080);    // C: lh, rdata B
        chk_wb("lbu", 1, 1, 5'd4, 32'h0000_0080);
        drive(1, 1, 1, 0, 2'b01, 5'd6, 32'h10C, 32'h0000_8001);    // D: l3b, rdata C
        chk_wb("lh", 1, 1, 5'd5, 32'hFFFF_8001);
        drive(1, 1, 1, 0, 2'b00, 5'd8, 32'h110, 32'h0080_0000);    // G: lw, rdata D
        chk_wb("l3b", 1, 1, 5'd6, 32'hFF80_0000);
        drive(1, 1, 0, 0, 2'b00, 5'd0, 32'h5, 32'h8765_4321);      // E: alu rd=0, rdata G
        chk_wb("lw", 1, 1, 5'd8, 32'h8765_4321);
        drive(0, 0, 0, 0, 2'b00, 5'd0, 32'h0, 32'h0);
        chk_wb("rd0", 1, 0, 5'd0, 32'h5);
        drive(0, 0, 0, 0, 2'b00, 5'd0, 32'h0, 32'h0);
        chk("bubble.valid", {31'd0, o_wb_valid}, 32'd0);

        // stall on a pending load
        drive(1, 1, 0, 0, 2'b00, 5'd11, 32'h11, 32'h0);            // K
        drive(1, 1, 1, 0, 2'b00, 5'd9, 32'h200, 32'h0);            // L: lw
        chk_wb("preStall", 1, 1, 5'd11, 32'h11);
        i_stall = 1'b1;
        drive(1, 1, 0, 0, 2'b00, 5'd10, 32'h77, 32'h1234_5678);    // M held in input
        chk_wb("stall1", 1, 1, 5'd11, 32'h11);
        drive(1, 1, 0, 0, 2'b00, 5'd10, 32'h77, 32'hDEAD_BEEF);
        chk_wb("stall2", 1, 1, 5'd11, 32'h11);
        drive(1, 1, 0, 0, 2'b00, 5'd10, 32'h77, 32'hDEAD_BEEF);
        chk_wb("stall3", 1, 1, 5'd11, 32'h11);
        i_stall = 1'b0;
        drive(1, 1, 0, 0, 2'b00, 5'd10, 32'h77, 32'hDEAD_BEEF);
        chk_wb("release", 1, 1, 5'd9, 32'h1234_5678);
        drive(0, 0, 0, 0, 2'b00, 5'd0, 32'h0, 32'h0);
        chk_wb("afterRel", 1, 1, 5'd10, 32'h77);

        // flush and stall together on a valid S1
        drive(1, 1, 0, 0, 2'b00, 5'd12, 32'h22, 32'h0);            // N
        i_stall = 1'b1; i_flush = 1'b1;
        drive(0, 0, 0, 0, 2'b00, 5'd0, 32'h0, 32'h0);
        chk("flush.hold", {31'd0, o_wb_valid}, 32'd0);
        i_stall = 1'b0; i_flush = 1'b0;
        drive(1, 1, 0, 0, 2'b00, 5'd13, 32'h33, 32'h0);            // P
        chk("flush.killed", {31'd0, o_wb_valid}, 32'd0);
        drive(0, 0, 0, 0, 2'b00, 5'd0, 32'h0, 32'h0);
        chk_wb("postFlush", 1, 1, 5'd13, 32'h33);

        // reset in the middle of a load
        drive(1, 1, 1, 0, 2'b00, 5'd14, 32'h300, 32'h0);           // R: lw
        rst = 1'b0;
        drive(0, 0, 0, 0, 2'b00, 5'd0, 32'h0, 32'hAAAA_5555);
        chk_wb("midRst", 0, 0, 5'd0, 32'h0);
        rst = 1'b1;
        drive(0, 0, 0, 0, 2'b00, 5'd0, 32'h0, 32'hAAAA_5555);
        chk("rstDiscard", {31'd0, o_wb_valid}, 32'd0);
`ifdef MEM_WB_RETIRE_CNT_EN
        chk("midRst.cnt", o_retire_count, 32'd0);
        for (int k = 0; k < 4; k++)
            drive(1, 1, 0, 0, 2'b00, 5'd1, 32'h0, 32'h0);
        drive(0, 0, 0, 0, 2'b00, 5'd0, 32'h0, 32'h0);
        drive(0, 0, 0, 0, 2'b00, 5'd0, 32'h0, 32'h0);
        chk("cnt4", o_retire_count, 32'd4);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
        $finish;
    end

endmodule
